regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (rd_address/rd_data) between two requesters:
  - the in-order pipeline writeback stage (primary);
  - a long-latency unit (mul/div, late loads) with valid/ready handshake (secondary).
- The long-latency result is captured in a one-entry holding buffer and written in a slot where writeback is idle.
- A starvation counter forces a drain by stalling writeback.
- Sits between writeback / long-latency unit and the regfile write port.

Parameters:
- XLEN, 32, data width of register values.
- MAX_WAIT, 4, max consecutive cycles a held result may be denied the port before a forced drain (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-high.
- wb_address  input  5  pipeline writeback destination; 0 = no write this cycle.
- wb_data  input  XLEN  pipeline writeback value.
- wb_stall  output  1  pipeline must hold wb_address/wb_data stable next cycle; the current wb write is not performed.
- lu_valid  input  1  long-latency unit presents a result.
- lu_address  input  5  destination of the long-latency result.
- lu_data  input  XLEN  long-latency result value.
- lu_ready  output  1  arbiter accepts the result this cycle (transfer = lu_valid & lu_ready).
- rd_address  output  5  to regfile write port; 0 = no write.
- rd_data  output  XLEN  to regfile write port.
- hold_valid  output  1  holding buffer occupied; decode uses this for hazard check.
- hold_address  output  5  destination held in the buffer (0 when empty).

Behaviour:
- Reset (reset=1 at a rising edge): hold_valid=0, hold_address=0, wait counter=0, stored data=0.
  - While reset is high: lu_ready=0, wb_stall=0, rd_address=0, rd_data=0.
  - Reset mid-operation discards any held result.
- State: HOLD_EMPTY / HOLD_FULL, encoded by hold_valid; plus wait counter cnt, width clog2(MAX_WAIT+1).
- lu_ready = ~hold_valid & ~reset. It is purely a state function, with no combinational path from lu_* or wb_*.
- Acceptance: a transfer with lu_address≠0 loads the buffer next edge and sets cnt=0.
  - A transfer with lu_address=0 is accepted and discarded; the buffer stays empty.
- Minimum latency from lu transfer to regfile write is 1 cycle; there is no direct lu→rd path.
- Combinational port selection each cycle (reset=0):
  1. Buffer empty: rd = wb_address/wb_data; wb_stall=0.
  2. Buffer full, wb_address=0: drain. rd = held entry; next edge hold_valid=0, cnt=0.
  3. Buffer full, wb_address=hold_address≠0: wb is newer in program order and supersedes the entry.
     - rd = wb; the entry is dropped (hold_valid=0 next edge); wb_stall=0.
  4. Buffer full, other wb_address, cnt<MAX_WAIT: rd = wb; cnt increments.
  5. Buffer full, other wb_address, cnt=MAX_WAIT: forced drain.
     - rd = held entry; wb_stall=1; next edge hold_valid=0, cnt=0.
     - Writeback is retried the following cycle (buffer then empty → case 1).
- Rule 3 takes precedence over rule 5.
- Buffer freed at an edge → lu_ready=1 on the next cycle. Sustained throughput is 1 result per 2 cycles.
- wb_stall is asserted only in case 5, so never on two consecutive cycles.
- hold_address mirrors the buffer destination and is 0 when the buffer is empty.
- No write is ever issued to x0; rd_address=0 means idle.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN default, DEFAULT_MAX_WAIT.
  - The package is shared with regfile/decode so hazard logic uses the same widths.
- Natural sub-module: regfile_hold_buffer. It holds the one-entry register (valid/address/data) with load/clear inputs.
- Arbitration and counter logic stay in the top.

Test Plan:
- Reset behaviour: reset held 2 cycles with lu_valid=1, wb_address=5 → lu_ready=0, rd_address=0, wb_stall=0, hold_valid=0. Release → lu_ready=1.
- Idle-slot drain: lu_valid=1 (addr 7, data 0xDEADBEEF), wb_address=0 → next cycle rd_address=7, rd_data=0xDEADBEEF. The cycle after, hold_valid=0 and lu_ready=1.
- Starvation (MAX_WAIT=4): buffer holds x9=0x1234. wb writes x1..x4 on 4 consecutive cycles → all pass through, cnt=4. On the 5th cycle with wb x5=0x55: rd=x9/0x1234 and wb_stall=1. Next cycle rd=x5/0x55.
- WAW supersede: buffer holds x3=0x11, wb_address=3, wb_data=0x22 → rd=x3/0x22. Buffer cleared with no later write of 0x11; regfile x3 ends at 0x22.
- x0 discard: lu transfer with lu_address=0 → hold_valid stays 0, lu_ready stays 1, no rd write.
- Mid-operation reset: buffer full with cnt=2, assert reset 1 cycle → hold_valid=0, and the held data is never written afterwards.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and defaults for the regfile write-port arbiter. Regfile and
// decode import this package too, so hazard logic uses the same widths.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DEFAULT_XLEN     = 32;
  localparam int DEFAULT_MAX_WAIT = 4;

  // Holding buffer occupancy; the encoding is simply hold_valid.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  function automatic hold_state_e hold_state(input logic valid);
    return valid ? HOLD_FULL : HOLD_EMPTY;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, long-latency handshake, regfile write port and
// holding-buffer status signals seen by the write-port arbiter.
interface regfile_write_arbiter_if
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) ();

  logic [REG_ADDR_W-1:0] wb_address;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_stall;

  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_address;
  logic [XLEN-1:0]       lu_data;
  logic                  lu_ready;

  logic [REG_ADDR_W-1:0] rd_address;
  logic [XLEN-1:0]       rd_data;

  logic                  hold_valid;
  logic [REG_ADDR_W-1:0] hold_address;

  // Environment side: pipeline, long-latency unit, regfile, decode.
  modport master (
    output wb_address, wb_data, lu_valid, lu_address, lu_data,
    input  wb_stall, lu_ready, rd_address, rd_data, hold_valid, hold_address
  );

  // Arbiter side.
  modport slave (
    input  wb_address, wb_data, lu_valid, lu_address, lu_data,
    output wb_stall, lu_ready, rd_address, rd_data, hold_valid, hold_address
  );

endinterface

// File: rtl/regfile_hold_buffer.sv
// One-entry holding register for a long-latency result waiting for a free
// regfile write slot. Load wins over clear; address reads 0 when empty.
module regfile_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] load_address,
  input  logic [XLEN-1:0]       load_data,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] address,
  output logic [XLEN-1:0]       data
);

  // Entry register: reset and clear empty it, load captures a new result.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      address <= '0;
      data    <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      address <= load_address;
      data    <= load_data;
    end else if (clear) begin
      valid   <= 1'b0;
      address <= '0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between pipeline writeback (primary)
// and a long-latency unit (secondary). Long-latency results are parked in a
// one-entry buffer and written in an idle writeback slot; a starvation
// counter forces a drain by stalling writeback for one cycle.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_WAIT);

  logic                  hold_valid;
  logic [REG_ADDR_W-1:0] hold_address;
  logic [XLEN-1:0]       hold_data;
  logic                  hold_load;
  logic                  hold_clear;

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;

  regfile_hold_buffer #(
    .XLEN (XLEN)
  ) u_hold (
    .clk          (clk),
    .reset        (reset),
    .load         (hold_load),
    .clear        (hold_clear),
    .load_address (bus.lu_address),
    .load_data    (bus.lu_data),
    .valid        (hold_valid),
    .address      (hold_address),
    .data         (hold_data)
  );

  assign bus.hold_valid   = hold_valid;
  assign bus.hold_address = hold_address;
  // State-only: never depends on lu_* or wb_* combinationally.
  assign bus.lu_ready     = ~hold_valid & ~reset;

  // Port selection, buffer load/clear and starvation counter update.
  always_comb begin
    bus.rd_address = '0;
    bus.rd_data    = '0;
    bus.wb_stall   = 1'b0;
    hold_load      = 1'b0;
    hold_clear     = 1'b0;
    cnt_next       = cnt;
    if (!reset) begin
      unique case (hold_state(hold_valid))
        HOLD_EMPTY: begin
          bus.rd_address = bus.wb_address;
          bus.rd_data    = bus.wb_data;
          // A result addressed to x0 is accepted but never stored.
          if (bus.lu_valid && (bus.lu_address != '0)) begin
            hold_load = 1'b1;
            cnt_next  = '0;
          end
        end
        HOLD_FULL: begin
          if (bus.wb_address == '0) begin
            // Writeback idle: drain the held result.
            bus.rd_address = hold_address;
            bus.rd_data    = hold_data;
            hold_clear     = 1'b1;
            cnt_next       = '0;
          end else if (bus.wb_address == hold_address) begin
            // Writeback is younger to the same register: drop the entry.
            bus.rd_address = bus.wb_address;
            bus.rd_data    = bus.wb_data;
            hold_clear     = 1'b1;
            cnt_next       = '0;
          end else if (cnt < CNT_MAX) begin
            bus.rd_address = bus.wb_address;
            bus.rd_data    = bus.wb_data;
            cnt_next       = cnt + CNT_W'(1);
          end else begin
            // Starved too long: write the entry, writeback retries next cycle.
            bus.rd_address = hold_address;
            bus.rd_data    = hold_data;
            bus.wb_stall   = 1'b1;
            hold_clear     = 1'b1;
            cnt_next       = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (XLEN=32, MAX_WAIT=4).
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] rf [32] = '{default: 32'h0};

  regfile_write_arbiter_if #(.XLEN(32)) bus ();

  regfile_write_arbiter #(
    .XLEN     (32),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference regfile built from the write port.
  always @(posedge clk) begin
    if (bus.rd_address != 5'd0) rf[bus.rd_address] <= bus.rd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] wba, input logic [31:0] wbd,
                       input logic luv, input logic [4:0] lua, input logic [31:0] lud);
    bus.wb_address = wba;
    bus.wb_data    = wbd;
    bus.lu_valid   = luv;
    bus.lu_address = lua;
    bus.lu_data    = lud;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'd5, 32'h5, 1'b1, 5'd7, 32'h77);

    // Reset held two edges with active inputs.
    cyc(); cyc();
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_address), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_wb_stall", 32'(bus.wb_stall), 32'd0);
    chk("rst_hold_valid", 32'(bus.hold_valid), 32'd0);
    chk("rst_hold_addr", 32'(bus.hold_address), 32'd0);
    drive(5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("rel_lu_ready", 32'(bus.lu_ready), 32'd1);

    // Idle-slot drain.
    drive(5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
    chk("drain_accept_rd", 32'(bus.rd_address), 32'd0);
    cyc();
    drive(5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drain_hold_valid", 32'(bus.hold_valid), 32'd1);
    chk("drain_hold_addr", 32'(bus.hold_address), 32'd7);
    chk("drain_lu_ready_full", 32'(bus.lu_ready), 32'd0);
    chk("drain_rd_addr", 32'(bus.rd_address), 32'd7);
    chk("drain_rd_data", bus.rd_data, 32'hDEADBEEF);
    chk("drain_wb_stall", 32'(bus.wb_stall), 32'd0);
    cyc();
    chk("drain_empty", 32'(bus.hold_valid), 32'd0);
    chk("drain_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("drain_hold_addr0", 32'(bus.hold_address), 32'd0);
    chk("drain_idle_rd", 32'(bus.rd_address), 32'd0);

    // Starvation: x9 held while wb writes x1..x4, then forced drain at x5.
    drive(5'd0, 32'h0, 1'b1, 5'd9, 32'h1234);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      drive(5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
      chk($sformatf("starve_pass_addr%0d", i), 32'(bus.rd_address), 32'(i));
      chk($sformatf("starve_pass_stall%0d", i), 32'(bus.wb_stall), 32'd0);
    end
    cyc();
    drive(5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    chk("starve_force_addr", 32'(bus.rd_address), 32'd9);
    chk("starve_force_data", bus.rd_data, 32'h1234);
    chk("starve_force_stall", 32'(bus.wb_stall), 32'd1);
    cyc();
    chk("starve_retry_addr", 32'(bus.rd_address), 32'd5);
    chk("starve_retry_data", bus.rd_data, 32'h55);
    chk("starve_retry_stall", 32'(bus.wb_stall), 32'd0);
    chk("starve_retry_empty", 32'(bus.hold_valid), 32'd0);

    // WAW supersede: held x3=0x11 replaced by writeback x3=0x22.
    drive(5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
    cyc();
    drive(5'd3, 32'h22, 1'b0, 5'd0, 32'h0);
    chk("waw_rd_addr", 32'(bus.rd_address), 32'd3);
    chk("waw_rd_data", bus.rd_data, 32'h22);
    chk("waw_stall", 32'(bus.wb_stall), 32'd0);
    cyc();
    drive(5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("waw_dropped", 32'(bus.hold_valid), 32'd0);
    chk("waw_no_late_write", 32'(bus.rd_address), 32'd0);
    cyc();
    chk("waw_rf_x3", rf[3], 32'h22);

    // x0 discard.
    drive(5'd0, 32'h0, 1'b1, 5'd0, 32'hAA);
    chk("x0_ready", 32'(bus.lu_ready), 32'd1);
    cyc();
    drive(5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("x0_hold_valid", 32'(bus.hold_valid), 32'd0);
    chk("x0_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("x0_rd_addr", 32'(bus.rd_address), 32'd0);

    // Mid-operation reset with x12 held and cnt=2.
    drive(5'd0, 32'h0, 1'b1, 5'd12, 32'hCAFE);
    cyc();
    drive(5'd1, 32'h201, 1'b0, 5'd0, 32'h0);
    cyc();
    drive(5'd2, 32'h202, 1'b0, 5'd0, 32'h0);
    cyc();
    drive(5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("mrst_pre_full", 32'(bus.hold_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst_rd_addr", 32'(bus.rd_address), 32'd0);
    chk("mrst_lu_ready", 32'(bus.lu_ready), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mrst_hold_valid", 32'(bus.hold_valid), 32'd0);
    chk("mrst_hold_addr", 32'(bus.hold_address), 32'd0);
    chk("mrst_rd_idle", 32'(bus.rd_address), 32'd0);
    cyc(); cyc(); cyc();
    chk("mrst_rf_x12", rf[12], 32'h0);
    chk("mrst_rf_x1", rf[1], 32'h201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
